uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
Transmit-side byte FIFO that sits directly upstream of the UART TX controller. The system side writes bytes with a simple write strobe. The TX controller pops one byte per frame with a single-cycle read pulse. The popped byte is presented on a registered output and held stable for the whole frame, until the next pop.

Parameters:
DATA_WIDTH, 8, width of each stored word and of tx_data
ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH (16 entries)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write strobe from system side; one word per cycle while high
wr_data  input  DATA_WIDTH  word written when wr_en accepted
tx_read_buf  input  1  pop request from TX controller; one pop per high cycle
tx_data  output  DATA_WIDTH  registered head word, valid after a pop, held until next pop
tx_buf_not_empty  output  1  high when count != 0
full  output  1  high when count == 2**ADDR_WIDTH
count  output  ADDR_WIDTH+1  number of stored words
overflow  output  1  sticky: a write was dropped
underflow  output  1  one-cycle pulse: pop requested while empty

Behaviour:
- Clock and reset: reset is synchronous and active-high; the clock is clock.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, tx_data=0, tx_buf_not_empty=0, full=0, overflow=0, underflow=0. Memory contents are not reset.
- Reset mid-operation: all stored words are discarded, and tx_data returns to 0 on the reset edge.
- Storage:
  - Array of 2**ADDR_WIDTH words.
  - Pointers are ADDR_WIDTH bits and wrap naturally from 2**ADDR_WIDTH-1 to 0.
  - count is ADDR_WIDTH+1 bits.
- Write accept: wr_en && (!full || pop_ok), where pop_ok = tx_read_buf && count != 0.
  - On an accepted write: mem[wr_ptr] <= wr_data and wr_ptr increments.
  - A write while full with a simultaneous valid pop is accepted.
- Write drop: wr_en && full && !pop_ok. The word is discarded, pointers are unchanged, and overflow <= 1. overflow stays set until reset.
- Pop: when pop_ok, tx_data <= mem[rd_ptr] on the same edge and rd_ptr increments.
  - tx_data is stable from the cycle after the pop edge until the next pop.
  - The TX controller samples tx_data many baud ticks later, so tx_data must not change between pops. There is no show-ahead output.
- Pop while empty: tx_read_buf && count == 0.
  - Pointers and tx_data are unchanged.
  - underflow is high for exactly the next cycle.
- count update:
  - +1 on an accepted write without a pop.
  - -1 on a pop without an accepted write.
  - Unchanged on a simultaneous write and pop, or when neither occurs.
- Write to an empty FIFO with a simultaneous pop request: the pop is invalid (count==0). It is treated as underflow, and the write is stored normally. There is no bypass of the new word onto tx_data.
- Latency:
  - A write accepted at edge N raises tx_buf_not_empty and count from edge N.
  - The earliest pop of that word is at edge N+1.
- Flags are derived from registered count (combinational compare or registered alongside count) and must be consistent with count in every cycle.
- Controller interaction:
  - The TX controller raises tx_read_buf for one cycle when it leaves idle, so the buffer sees exactly one pop per frame.
  - tx_buf_not_empty may stay high while a frame is in flight; this is legal.

Test Plan:
- Reset, then write 8'hA5 and 8'h3C on consecutive cycles -> count=2, tx_buf_not_empty=1 after the second edge; pulse tx_read_buf -> tx_data=8'hA5, count=1; second pulse -> tx_data=8'h3C, count=0, tx_buf_not_empty=0.
- Hold tx_data: after popping 8'h55, write 8'hFF and idle 1000 cycles -> tx_data stays 8'h55 until the next pop.
- Fill 16 words 0x00..0x0F -> full=1, count=16; a 17th write of 0xEE -> dropped, overflow=1; pop all 16 -> 0x00..0x0F in order, and 0xEE never appears.
- Full with simultaneous wr_en (0x77) and tx_read_buf -> count stays 16, overflow stays 0; 0x77 is popped as the 16th subsequent word.
- Wrap-around: 40 interleaved write/pop pairs with an incrementing pattern -> output sequence matches input exactly across pointer wrap; count never exceeds 1.
- Empty pop -> underflow pulses for one cycle, tx_data unchanged; reset asserted with count=5 -> count=0, tx_data=0, overflow=0 the next cycle.

Source files
------------

// File: rtl/uart_tx_buf_if.sv
// Signal bundle between the system-side writer, the TX buffer and the TX controller.
// wr_en is a write-valid whose implicit ready is (!full || valid pop); tx_read_buf is a pop strobe honoured only when count != 0.
interface uart_tx_buf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  tx_read_buf;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_buf_not_empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, tx_read_buf,
    input  tx_data, tx_buf_not_empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, tx_read_buf,
    output tx_data, tx_buf_not_empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/uart_tx_buf.sv
// Transmit byte FIFO feeding the UART TX controller; the popped word is held
// on a registered output for the whole frame until the next pop.
module uart_tx_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic          clock,
  input logic          reset,
  uart_tx_buf_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  pop_ok;
  logic                  wr_ok;
  logic                  wr_drop;

  // A pop frees a slot on the same edge, so a full buffer still accepts a write alongside a valid pop.
  always_comb begin
    pop_ok  = bus.tx_read_buf && (count_q != '0);
    wr_ok   = bus.wr_en && ((count_q != FULL_COUNT) || pop_ok);
    wr_drop = bus.wr_en && !wr_ok;
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      tx_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= bus.tx_read_buf && (count_q == '0);
      if (wr_drop) overflow_q <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok) begin
        tx_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({wr_ok, pop_ok})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.tx_data          = tx_data_q;
  assign bus.count            = count_q;
  assign bus.tx_buf_not_empty = (count_q != '0);
  assign bus.full             = (count_q == FULL_COUNT);
  assign bus.overflow         = overflow_q;
  assign bus.underflow        = underflow_q;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: a queue scoreboard holds accepted words,
// and each scenario task compares DUT outputs against it and against fixed values.
module tb_uart_tx_buf;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx_buf_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
  uart_tx_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] mdl_count;
  logic [7:0] mdl_tx;
  logic       mdl_ovf;
  logic       mdl_unf;

  // One clock of stimulus; the reference model is advanced alongside it.
  task automatic drive(input logic we, input logic [7:0] wd, input logic rd);
    logic pop_ok, wr_ok;
    pop_ok = rd && (mdl_count != 0);
    wr_ok  = we && ((mdl_count != 5'd16) || pop_ok);
    bus.wr_en = we; bus.wr_data = wd; bus.tx_read_buf = rd;
    @(posedge clock); #1;
    bus.wr_en = 1'b0; bus.tx_read_buf = 1'b0;
    mdl_unf = rd && (mdl_count == 0);
    if (we && !wr_ok) mdl_ovf = 1'b1;
    if (pop_ok && exp_q.size() > 0) mdl_tx = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(wd);
    if (wr_ok && !pop_ok) mdl_count = mdl_count + 5'd1;
    else if (pop_ok && !wr_ok) mdl_count = mdl_count - 5'd1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.tx_read_buf = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    mdl_count = '0; mdl_tx = '0; mdl_ovf = 1'b0; mdl_unf = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.count, bus.tx_data, bus.tx_buf_not_empty, bus.full, bus.overflow, bus.underflow} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d tx=%h ne=%b full=%b ovf=%b unf=%b, expected all zero",
               bus.count, bus.tx_data, bus.tx_buf_not_empty, bus.full, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b1, 8'h3C, 1'b0);
    n_checks++;
    if (bus.count !== 5'd2 || bus.tx_buf_not_empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_fill: count=%0d ne=%b, expected 2 and 1", bus.count, bus.tx_buf_not_empty);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus.tx_data !== 8'hA5 || bus.count !== 5'd1 || bus.tx_data !== mdl_tx) begin
      n_fail++; $display("FAIL basic_pop1: tx=%h count=%0d, expected a5 and 1", bus.tx_data, bus.count);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus.tx_data !== 8'h3C || bus.count !== 5'd0 || bus.tx_buf_not_empty !== 1'b0) begin
      n_fail++; $display("FAIL basic_pop2: tx=%h count=%0d ne=%b, expected 3c 0 0", bus.tx_data, bus.count, bus.tx_buf_not_empty);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (bus.tx_data !== 8'h55) begin
        n_fail++; $display("FAIL hold_tx cycle %0d: tx=%h, expected 55", i, bus.tx_data);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus.tx_data !== 8'hFF || bus.count !== 5'd0) begin
      n_fail++; $display("FAIL hold_next_pop: tx=%h count=%0d, expected ff and 0", bus.tx_data, bus.count);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      n_fail++; $display("FAIL simul_full: full=%b count=%0d, expected 1 and 16", bus.full, bus.count);
    end
    drive(1'b1, 8'h77, 1'b1);
    n_checks++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.tx_data !== 8'h20) begin
      n_fail++; $display("FAIL simul_wr_pop: count=%0d ovf=%b tx=%h, expected 16 0 20", bus.count, bus.overflow, bus.tx_data);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus.tx_data !== mdl_tx) begin
        n_fail++; $display("FAIL simul_drain %0d: tx=%h, expected %h", i, bus.tx_data, mdl_tx);
      end
      if (i == 15) begin
        n_checks++;
        if (bus.tx_data !== 8'h77 || bus.count !== 5'd0) begin
          n_fail++; $display("FAIL simul_last: tx=%h count=%0d, expected 77 and 0", bus.tx_data, bus.count);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] pat;
    for (int i = 0; i < 40; i++) begin
      pat = 8'(i * 3 + 1);
      drive(1'b1, pat, 1'b0);
      n_checks++;
      if (bus.count > 5'd1 || bus.count !== mdl_count) begin
        n_fail++; $display("FAIL wrap_count %0d: count=%0d, expected %0d", i, bus.count, mdl_count);
      end
      drive(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus.tx_data !== pat || bus.count !== 5'd0) begin
        n_fail++; $display("FAIL wrap_data %0d: tx=%h count=%0d, expected %h and 0", i, bus.tx_data, bus.count, pat);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] held;
    held = mdl_tx;
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.tx_data !== held || bus.count !== 5'd0) begin
      n_fail++; $display("FAIL underflow_pulse: unf=%b tx=%h count=%0d, expected 1 %h 0", bus.underflow, bus.tx_data, bus.count, held);
    end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (bus.underflow !== mdl_unf || bus.underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear: unf=%b, expected 0", bus.underflow);
    end
    drive(1'b1, 8'h9A, 1'b1);
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd1 || bus.tx_data !== held) begin
      n_fail++; $display("FAIL underflow_with_write: unf=%b count=%0d tx=%h, expected 1 1 %h", bus.underflow, bus.count, bus.tx_data, held);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus.tx_data !== 8'h9A || bus.underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_then_pop: tx=%h unf=%b, expected 9a 0", bus.tx_data, bus.underflow);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill: full=%b count=%0d ovf=%b, expected 1 16 0", bus.full, bus.count, bus.overflow);
    end
    drive(1'b1, 8'hEE, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== mdl_ovf) begin
      n_fail++; $display("FAIL ovf_drop: ovf=%b count=%0d, expected 1 16", bus.overflow, bus.count);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus.tx_data !== 8'(i) || bus.tx_data !== mdl_tx) begin
        n_fail++; $display("FAIL ovf_drain %0d: tx=%h, expected %h", i, bus.tx_data, 8'(i));
      end
    end
    n_checks++;
    if (bus.count !== 5'd0 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: count=%0d ovf=%b, expected 0 1", bus.count, bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom_range(1, 255)), 1'b0);
    n_checks++;
    if (bus.count !== 5'd5 || bus.tx_data !== 8'h0F) begin
      n_fail++; $display("FAIL mid_pre: count=%0d tx=%h, expected 5 0f", bus.count, bus.tx_data);
    end
    apply_reset();
    n_checks++;
    if (bus.count !== 5'd0 || bus.tx_data !== 8'h00 || bus.overflow !== 1'b0 || bus.tx_buf_not_empty !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: count=%0d tx=%h ovf=%b ne=%b, expected all zero", bus.count, bus.tx_data, bus.overflow, bus.tx_buf_not_empty);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.tx_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_discard: unf=%b tx=%h, expected 1 00", bus.underflow, bus.tx_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.tx_read_buf = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    apply_reset();
    test_full_simul();
    test_wrap();
    test_underflow();
    test_fill_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
